// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two-requester round-robin controller time-sharing one
// external combinational 32-bit ALU. Operands and opcode are driven from
// registers; after ALU_LAT cycles the ALU result and flags are registered
// and returned to the winning requester over a valid/ready channel.
// Optional macro ALU_SHARE_OPCNT_EN adds ops_done (completed-response count)
// and grant_last (the requester served most recently).
module alu_share_ctrl #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [3:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       rsp1_flags,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_parity,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_carry
`ifdef ALU_SHARE_OPCNT_EN
  ,
  output logic [15:0]      ops_done,
  output logic             grant_last
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_t     state, state_nxt;
  logic       last_grant;   // requester served most recently
  logic       owner;        // requester of the in-flight operation
  logic [3:0] lat_cnt;
  logic       grant0, grant1;
  logic       owner_rsp_ready;
  logic       accept, capture, complete;

  // Round-robin winner: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    grant0          = req0_valid && (!req1_valid || last_grant);
    grant1          = req1_valid && (!req0_valid || !last_grant);
    owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
    accept          = (state == IDLE) && (grant0 || grant1);
    capture         = (state == EXEC) && (lat_cnt == 4'd0);
    complete        = (state == RESP) && owner_rsp_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and request-ready decode
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    if (lat_cnt == 4'd0) state_nxt = RESP;
      RESP:    if (owner_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, latency countdown, result registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      lat_cnt     <= 4'd0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_opcode  <= 4'd0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= 4'd0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= 4'd0;
    end else begin
      if (accept) begin
        owner      <= grant1;
        alu_opcode <= grant1 ? req1_op : req0_op;
        alu_in1    <= grant1 ? req1_a  : req0_a;
        alu_in2    <= grant1 ? req1_b  : req0_b;
        lat_cnt    <= LAT_INIT;
      end else if ((state == EXEC) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      if (capture) begin
        if (owner) begin
          rsp1_valid  <= 1'b1;
          rsp1_result <= alu_out;
          rsp1_flags  <= {alu_carry, alu_sign, alu_zero, alu_parity};
        end else begin
          rsp0_valid  <= 1'b1;
          rsp0_result <= alu_out;
          rsp0_flags  <= {alu_carry, alu_sign, alu_zero, alu_parity};
        end
      end

      if (complete) begin
        last_grant <= owner;
        if (owner) rsp1_valid <= 1'b0;
        else       rsp0_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_OPCNT_EN
  // Count completed response handshakes, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst)           ops_done <= 16'd0;
    else if (complete) ops_done <= ops_done + 16'd1;
  end

  assign grant_last = last_grant;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl. Two instances (ALU_LAT=1 and 3)
// each drive a behavioural ALU; a transaction-level model predicts the
// round-robin winner, the latency and the returned result/flags.
module tb_alu_share_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-instance signals, first index = instance, second = requester
  logic        rst        [2];
  logic        req_valid  [2][2];
  logic        req_ready  [2][2];
  logic [3:0]  req_op     [2][2];
  logic [31:0] req_a      [2][2];
  logic [31:0] req_b      [2][2];
  logic        rsp_valid  [2][2];
  logic        rsp_ready  [2][2];
  logic [31:0] rsp_result [2][2];
  logic [3:0]  rsp_flags  [2][2];
  logic [31:0] alu_in1    [2];
  logic [31:0] alu_in2    [2];
  logic [3:0]  alu_opcode [2];
  logic [35:0] alu_res    [2];
`ifdef ALU_SHARE_OPCNT_EN
  logic [15:0] ops_done   [2];
  logic        grant_last [2];
`endif

  // Model state per instance
  int last_srv [2];
  int ops      [2];

  // Behavioural ALU: returns {carry, sign, zero, parity, result}
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0:    r = s[31:0];
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = a & b;
      4'd4:    r = a | b;
      4'd5:    r = a ^ b;
      4'd13:   r = a + 32'd1;
      default: r = a;
    endcase
    return {s[32], r[31], (r == 32'd0), ~^r, r};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    alu_share_ctrl #(.ALU_LAT((k == 0) ? LAT0 : LAT1), .WIDTH(32)) u_dut (
      .clk         (clk),
      .rst         (rst[k]),
      .req0_valid  (req_valid[k][0]),
      .req0_ready  (req_ready[k][0]),
      .req0_op     (req_op[k][0]),
      .req0_a      (req_a[k][0]),
      .req0_b      (req_b[k][0]),
      .req1_valid  (req_valid[k][1]),
      .req1_ready  (req_ready[k][1]),
      .req1_op     (req_op[k][1]),
      .req1_a      (req_a[k][1]),
      .req1_b      (req_b[k][1]),
      .rsp0_valid  (rsp_valid[k][0]),
      .rsp0_ready  (rsp_ready[k][0]),
      .rsp0_result (rsp_result[k][0]),
      .rsp0_flags  (rsp_flags[k][0]),
      .rsp1_valid  (rsp_valid[k][1]),
      .rsp1_ready  (rsp_ready[k][1]),
      .rsp1_result (rsp_result[k][1]),
      .rsp1_flags  (rsp_flags[k][1]),
      .alu_in1     (alu_in1[k]),
      .alu_in2     (alu_in2[k]),
      .alu_opcode  (alu_opcode[k]),
      .alu_out     (alu_res[k][31:0]),
      .alu_parity  (alu_res[k][32]),
      .alu_zero    (alu_res[k][33]),
      .alu_sign    (alu_res[k][34]),
      .alu_carry   (alu_res[k][35])
`ifdef ALU_SHARE_OPCNT_EN
      ,
      .ops_done    (ops_done[k]),
      .grant_last  (grant_last[k])
`endif
    );
    assign alu_res[k] = alu_fn(alu_opcode[k], alu_in1[k], alu_in2[k]);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input int j, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[k][j] = 1'b1;
    req_op[k][j]    = op;
    req_a[k][j]     = a;
    req_b[k][j]     = b;
  endtask

  // Called at a negedge: holds reset for two edges with requests asserted
  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    req_valid[k][0] = 1'b1;
    req_valid[k][1] = 1'b1;
    @(negedge clk);
    check($sformatf("i%0d_rst1_rspv", k), {rsp_valid[k][1], rsp_valid[k][0]}, 2'b00);
    check($sformatf("i%0d_rst1_rdy", k), {req_ready[k][1], req_ready[k][0]}, 2'b00);
    @(negedge clk);
    check($sformatf("i%0d_rst_rdy", k), {req_ready[k][1], req_ready[k][0]}, 2'b00);
    check($sformatf("i%0d_rst_rsp", k),
          {rsp_valid[k][1], rsp_valid[k][0], rsp_result[k][1], rsp_result[k][0]}, 64'd0);
    check($sformatf("i%0d_rst_flags", k), {rsp_flags[k][1], rsp_flags[k][0]}, 8'd0);
    check($sformatf("i%0d_rst_alu", k), {alu_in1[k], alu_in2[k]}, 64'd0);
    check($sformatf("i%0d_rst_opc", k), alu_opcode[k], 4'd0);
`ifdef ALU_SHARE_OPCNT_EN
    check($sformatf("i%0d_rst_opsdone", k), ops_done[k], 16'd0);
`endif
    rst[k] = 1'b0;
    req_valid[k][0] = 1'b0;
    req_valid[k][1] = 1'b0;
    last_srv[k] = 1;
    ops[k] = 0;
  endtask

  // Called at a negedge with requests driven: one complete transaction
  task automatic serve(input int k, input int hold, output int who,
                       output logic [31:0] res, output logic [3:0] fl);
    int          exp_w, oth, cnt, lat;
    logic [35:0] e;
    logic [31:0] a, b;
    logic [3:0]  op;
    bit          bad;
    lat = (k == 0) ? LAT0 : LAT1;
    #1;
    if (req_valid[k][0] && req_valid[k][1]) exp_w = 1 - last_srv[k];
    else if (req_valid[k][1])               exp_w = 1;
    else                                    exp_w = 0;
    oth = 1 - exp_w;
    check($sformatf("i%0d_grant", k), {req_ready[k][1], req_ready[k][0]},
          (exp_w == 1) ? 2'b10 : 2'b01);
    op = req_op[k][exp_w];
    a  = req_a[k][exp_w];
    b  = req_b[k][exp_w];
    e  = alu_fn(op, a, b);
    rsp_ready[k][exp_w] = (hold == 0);
    rsp_ready[k][oth]   = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid[k][exp_w] = 1'b0;
    cnt = 0;
    bad = 1'b0;
    while (!rsp_valid[k][exp_w] && cnt < 40) begin
      bad |= req_ready[k][0] | req_ready[k][1] | rsp_valid[k][oth];
      @(negedge clk);
      cnt++;
    end
    check($sformatf("i%0d_latency", k), cnt, lat);
    res = rsp_result[k][exp_w];
    fl  = rsp_flags[k][exp_w];
    check($sformatf("i%0d_result", k), res, e[31:0]);
    check($sformatf("i%0d_flags", k), fl, e[35:32]);
    check($sformatf("i%0d_alu_ops", k), {alu_opcode[k], alu_in1[k], alu_in2[k]}, {op, a, b});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bad |= !rsp_valid[k][exp_w] || (rsp_result[k][exp_w] != e[31:0]) ||
             (rsp_flags[k][exp_w] != e[35:32]) || req_ready[k][0] || req_ready[k][1] ||
             rsp_valid[k][oth];
    end
    check($sformatf("i%0d_busy_quiet", k), bad, 1'b0);
    rsp_ready[k][exp_w] = 1'b1;
    @(negedge clk);
    check($sformatf("i%0d_rsp_drop", k), rsp_valid[k][exp_w], 1'b0);
    check($sformatf("i%0d_alu_hold", k), {alu_in1[k], alu_in2[k]}, {a, b});
    rsp_ready[k][exp_w] = 1'($urandom_range(0, 1));
    last_srv[k] = exp_w;
    ops[k]++;
`ifdef ALU_SHARE_OPCNT_EN
    check($sformatf("i%0d_opsdone", k), ops_done[k], 16'(ops[k]));
    check($sformatf("i%0d_grant_last", k), grant_last[k], 1'(exp_w));
`endif
    who = exp_w;
  endtask

  task automatic run(input int k);
    int          who;
    logic [31:0] res;
    logic [3:0]  fl;
    do_reset(k);

    // Simple add, carry-free, and wrap to zero
    set_req(k, 0, 4'd0, 32'd5, 32'd7);
    serve(k, 0, who, res, fl);
    check($sformatf("i%0d_add_res", k), {who[0], res, fl}, {1'b0, 32'd12, 4'b0001});
    set_req(k, 0, 4'd0, 32'hFFFF_FFFF, 32'd1);
    serve(k, 1, who, res, fl);
    check($sformatf("i%0d_wrap_res", k), {res, fl}, {32'd0, 4'b1011});

    // Both held valid after reset: strict alternation starting with req0
    do_reset(k);
    set_req(k, 0, 4'd1, 32'd10, 32'd3);
    set_req(k, 1, 4'd3, 32'hF0, 32'h3C);
    for (int i = 0; i < 4; i++) begin
      serve(k, int'($urandom_range(0, 2)), who, res, fl);
      check($sformatf("i%0d_rr_%0d", k, i), {who[0], res},
            {1'(i % 2), ((i % 2) != 0) ? 32'h30 : 32'd7});
      req_valid[k][who] = 1'b1;
    end
    req_valid[k][0] = 1'b0;
    req_valid[k][1] = 1'b0;

    // Response back-pressure for five cycles
    set_req(k, 1, 4'd13, 32'd41, 32'd0);
    serve(k, 5, who, res, fl);
    check($sformatf("i%0d_bp_res", k), {who[0], res}, {1'b1, 32'd42});

    // Multiply through the configured latency
    set_req(k, 0, 4'd2, 32'd6, 32'd7);
    serve(k, 0, who, res, fl);
    check($sformatf("i%0d_mul_res", k), res, 32'd42);

    // Reset while executing: operation abandoned, next request served normally
    set_req(k, 0, 4'd0, 32'd100, 32'd200);
    #1;
    check($sformatf("i%0d_mx_acc", k), req_ready[k][0], 1'b1);
    @(negedge clk);
    req_valid[k][0] = 1'b0;
    do_reset(k);
    set_req(k, 1, 4'd5, 32'hA5A5_0000, 32'h0000_5A5A);
    serve(k, 0, who, res, fl);
    check($sformatf("i%0d_mx_next", k), {who[0], res}, {1'b1, 32'hA5A5_5A5A});

    // Three completions after reset
    do_reset(k);
    for (int i = 0; i < 3; i++) begin
      set_req(k, i % 2, 4'd4, $urandom, $urandom);
      serve(k, 0, who, res, fl);
    end
`ifdef ALU_SHARE_OPCNT_EN
    check($sformatf("i%0d_ops3", k), ops_done[k], 16'd3);
`endif

    // Randomised traffic with held, competing requests
    for (int i = 0; i < 120; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!req_valid[k][j] && $urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 7) == 0) set_req(k, j, 4'($urandom), 32'd0, 32'd0);
          else                           set_req(k, j, 4'($urandom), $urandom, $urandom);
        end
      end
      if (!req_valid[k][0] && !req_valid[k][1])
        set_req(k, int'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      serve(k, int'($urandom_range(0, 3)), who, res, fl);
    end
    req_valid[k][0] = 1'b0;
    req_valid[k][1] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      last_srv[k] = 1;
      ops[k] = 0;
      for (int j = 0; j < 2; j++) begin
        req_valid[k][j] = 1'b0;
        req_op[k][j]    = 4'd0;
        req_a[k][j]     = 32'd0;
        req_b[k][j]     = 32'd0;
        rsp_ready[k][j] = 1'b0;
      end
    end
    @(negedge clk);
    run(0);
    run(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
